// File: rtl/instr_mem_loader.sv
// Purpose: byte-stream loader writing a little-endian program image into instruction memory; holds the core until done.
// Latency: mem_we pulses the cycle after the 4th byte of each word (>= 5 cycles/word); DONE/ERROR the cycle after the header.
// Backpressure: in_ready is low in WRITE, DONE and ERROR; the sender must hold its byte until in_ready returns.
module instr_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256   // must not exceed 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active-low
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           word_count
);

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_byte_cnt;
  logic [15:0]           r_word_idx;
  logic [15:0]           r_word_count;
  logic [23:0]           r_wbuf;       // bytes 0..2 of the word being assembled
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;

  logic                  w_xfer;
  logic [15:0]           w_n;          // full word count as seen during the HDR1 transfer
  logic [15:0]           w_idx_inc;

  assign w_xfer    = in_valid && in_ready;
  assign w_n       = {in_data, r_word_count[7:0]};
  assign w_idx_inc = r_word_idx + 16'd1;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_HDR0;
    else      r_state <= w_next;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_next     = r_state;
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    load_done  = 1'b0;
    load_error = 1'b0;
    core_hold  = 1'b1;
    unique case (r_state)
      S_HDR0: begin
        in_ready = 1'b1;
        if (w_xfer) w_next = S_HDR1;
      end
      S_HDR1: begin
        in_ready = 1'b1;
        if (w_xfer) begin
          if (w_n == 16'd0)                 w_next = S_DONE;
          else if (w_n > 16'(MAX_WORDS))    w_next = S_ERROR;
          else                              w_next = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (w_xfer && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (w_idx_inc == r_word_count) w_next = S_DONE;
        else                           w_next = S_DATA;
      end
      S_DONE: begin
        load_done = 1'b1;
        core_hold = 1'b0;
        if (start) w_next = S_HDR0;
      end
      S_ERROR: begin
        load_error = 1'b1;
        if (start) w_next = S_HDR0;
      end
      default: w_next = S_HDR0;
    endcase
  end

  // Datapath: header capture, byte assembly, write address/data staging and counters.
  // Address/data are captured on the 4th byte so they are stable during WRITE and hold afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt   <= 2'd0;
      r_word_idx   <= 16'd0;
      r_word_count <= 16'd0;
      r_wbuf       <= 24'd0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
    end else begin
      unique case (r_state)
        S_HDR0: if (w_xfer) r_word_count <= {8'h00, in_data};
        S_HDR1: if (w_xfer) begin
          r_word_count <= w_n;
          r_word_idx   <= 16'd0;
          r_byte_cnt   <= 2'd0;
        end
        S_DATA: if (w_xfer) begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            r_mem_addr  <= r_word_idx[ADDR_WIDTH-1:0];
            r_mem_wdata <= {in_data, r_wbuf};
          end else begin
            r_wbuf[{r_byte_cnt, 3'b000} +: 8] <= in_data;
          end
        end
        S_WRITE: r_word_idx <= w_idx_inc;
        S_DONE, S_ERROR: if (start) begin
          r_word_count <= 16'd0;
          r_word_idx   <= 16'd0;
          r_byte_cnt   <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Purpose: randomized scoreboard bench for instr_mem_loader against a queue-based image model.
// Latency: checks mem_we one cycle after each word's 4th byte, DONE/ERROR one cycle after the header.
// Backpressure: driver holds each byte until in_ready, with none/alternating/random idle gaps.
module tb_instr_mem_loader;

  localparam int AW   = 8;
  localparam int MAXW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_hold;
  logic          load_done;
  logic          load_error;
  logic [15:0]   word_count;

  instr_mem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_error(load_error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_writes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected (addr, data).
  always @(negedge clk) begin
    if (rst && mem_we) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        chk("unexpected write addr", 32'(mem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write addr", 32'(mem_addr), 32'(e.a));
        chk("write data", mem_wdata, e.d);
      end
    end
  end

  // Drive one byte from a negedge; returns at the negedge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int w;
    w = 0;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      chk("in_ready timeout", 32'd0, 32'd1);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic wait_end();
    int c;
    c = 0;
    while (!(load_done || load_error) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (!(load_done || load_error)) chk("end-of-load timeout", 32'd0, 32'd1);
  endtask

  // Send header n and the first n words of img; model pushes expected writes.
  task automatic do_load(input int n, input int mode);
    int w0;
    logic [15:0] nn;
    logic [31:0] wd;
    w0 = n_writes;
    nn = 16'(n);
    if (n <= MAXW)
      for (int i = 0; i < n; i++) exp_q.push_back('{a: AW'(i), d: img[i]});
    send_byte(nn[7:0], pick_gap(mode));
    send_byte(nn[15:8], pick_gap(mode));
    if (n == 0) chk("N=0 done next cycle", 32'(load_done), 32'd1);
    if (n > MAXW) chk("overflow error next cycle", 32'(load_error), 32'd1);
    if (n > 0 && n <= MAXW) begin
      for (int i = 0; i < n; i++) begin
        wd = img[i];
        for (int k = 0; k < 4; k++) send_byte(wd[8*k +: 8], pick_gap(mode));
        chk("mem_we after 4th byte", 32'(mem_we), 32'd1);
      end
    end
    wait_end();
    repeat (2) @(negedge clk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    chk("write count", 32'(n_writes - w0), (n <= MAXW) ? 32'(n) : 32'd0);
    chk("word_count", 32'(word_count), 32'(nn));
    chk("load_done", 32'(load_done), (n <= MAXW) ? 32'd1 : 32'd0);
    chk("load_error", 32'(load_error), (n > MAXW) ? 32'd1 : 32'd0);
    chk("core_hold", 32'(core_hold), (n <= MAXW) ? 32'd0 : 32'd1);
    chk("in_ready idle", 32'(in_ready), 32'd0);
    exp_q.delete();
  endtask

  task automatic restart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart load_done", 32'(load_done), 32'd0);
    chk("restart load_error", 32'(load_error), 32'd0);
    chk("restart core_hold", 32'(core_hold), 32'd1);
    chk("restart in_ready", 32'(in_ready), 32'd1);
    chk("restart word_count", 32'(word_count), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " load_done"}, 32'(load_done), 32'd0);
    chk({tag, " load_error"}, 32'(load_error), 32'd0);
    chk({tag, " core_hold"}, 32'(core_hold), 32'd1);
    chk({tag, " word_count"}, 32'(word_count), 32'd0);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
    @(negedge clk);

    // Directed N=2 image.
    img.delete();
    img.push_back(32'h0010_0513);
    img.push_back(32'h00B5_05B3);
    do_load(2, 0);
    restart();

    // N=0.
    do_load(0, 0);
    restart();

    // N=300 overflow, then a random oversize count.
    do_load(300, 0);
    restart();
    do_load(int'($urandom_range(MAXW + 1, 65535)), 2);
    restart();

    // Alternating in_valid gaps.
    img.delete();
    img.push_back($urandom);
    do_load(1, 1);
    restart();

    // Randomized images and gap patterns.
    for (int t = 0; t < 5; t++) begin
      n = int'($urandom_range(1, 8));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      do_load(n, int'($urandom_range(0, 2)));
      restart();
    end

    // Reset mid-load: word 0 complete, word 1 has two bytes.
    img.delete();
    img.push_back(32'hCAFE_F00D);
    exp_q.push_back('{a: AW'(0), d: 32'hCAFE_F00D});
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst = 1'b0;
    #1 check_reset_vals("midload reset");
    chk("midload word0 written", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    img.delete();
    img.push_back($urandom);
    do_load(1, 2);
    restart();

    // Boundary: N=MAX_WORDS, word i = i.
    img.delete();
    for (int i = 0; i < MAXW; i++) img.push_back(32'(i));
    do_load(MAXW, 0);
    chk("final addr held", 32'(mem_addr), 32'(MAXW - 1));
    chk("final data held", mem_wdata, 32'h0000_00FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
